// File: rtl/seven_segment_pkg.sv
// Shared types and helpers for the seven-segment scan controller slice.
package seven_segment_pkg;

   localparam int unsigned CODE_W = 4;

   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_SHOW  = 1'b1
   } phase_e;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seven_segment_scan_controller_if.sv
// Host-side load/control signals and display-side scan outputs of the scan controller.
interface seven_segment_scan_controller_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   import seven_segment_pkg::*;

   localparam int unsigned IDX_W  = idx_width(NUM_DIGITS);
   localparam int unsigned DATA_W = CODE_W * NUM_DIGITS;

   logic                  enable;
   logic                  load;
   logic [DATA_W-1:0]     data_in;
   logic [NUM_DIGITS-1:0] dp_in;
   logic [NUM_DIGITS-1:0] mask_in;
   logic                  lzb;

   logic [CODE_W-1:0]     code;
   logic                  dp;
   logic [NUM_DIGITS-1:0] digit_en;
   logic [IDX_W-1:0]      digit_idx;
   logic                  frame_start;
   logic                  pending;

   modport master (
      output enable, load, data_in, dp_in, mask_in, lzb,
      input  code, dp, digit_en, digit_idx, frame_start, pending
   );

   modport slave (
      input  enable, load, data_in, dp_in, mask_in, lzb,
      output code, dp, digit_en, digit_idx, frame_start, pending
   );

endinterface

// File: rtl/seven_segment_prescaler.sv
// Digit-slot counter: counts 0..PRESCALE-1 while enabled and flags the last cycle of a slot.
module seven_segment_prescaler
   import seven_segment_pkg::*;
#(
   parameter int unsigned PRESCALE = 50000,
   parameter int unsigned CNT_W    = idx_width(PRESCALE)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             wrap_c
);

   assign wrap_c = enable && (count == CNT_W'(PRESCALE - 1));

   // Counter holds its position while disabled so a paused slot resumes where it stopped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (enable) begin
         if (wrap_c) count <= '0;
         else        count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed scanner for a common-bus seven-segment display with
// inter-digit blanking and frame-synchronous double-buffered updates.
module seven_segment_scan_controller
   import seven_segment_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned PRESCALE     = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic                              clk,
   input  logic                              rst_n,
   seven_segment_scan_controller_if.slave    bus
);

   localparam int unsigned IDX_W = idx_width(NUM_DIGITS);
   localparam int unsigned CNT_W = idx_width(PRESCALE);

   logic [CNT_W-1:0]                   slot_cnt;
   logic                               slot_wrap_c;
   logic [IDX_W-1:0]                   idx_q;
   logic                               last_idx_c;
   logic                               frame_edge_c;
   phase_e                             phase_c;

   logic [NUM_DIGITS-1:0][CODE_W-1:0]  active_code_q;
   logic [NUM_DIGITS-1:0]              active_dp_q;
   logic [NUM_DIGITS-1:0]              active_mask_q;
   logic [NUM_DIGITS-1:0][CODE_W-1:0]  shadow_code_q;
   logic [NUM_DIGITS-1:0]              shadow_dp_q;
   logic [NUM_DIGITS-1:0]              shadow_mask_q;
   logic                               pending_q;

   logic [NUM_DIGITS-1:0]              lead_blank_c;
   logic [NUM_DIGITS-1:0]              visible_c;
   logic [NUM_DIGITS-1:0]              onehot_c;
   logic                               zero_run_c;

   seven_segment_prescaler #(
      .PRESCALE (PRESCALE),
      .CNT_W    (CNT_W)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (bus.enable),
      .count  (slot_cnt),
      .wrap_c (slot_wrap_c)
   );

   assign last_idx_c   = (idx_q == IDX_W'(NUM_DIGITS - 1));
   assign frame_edge_c = slot_wrap_c && last_idx_c;
   assign phase_c      = (slot_cnt < CNT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
   assign onehot_c     = NUM_DIGITS'(1) << idx_q;

   // Digit index advances once per slot and wraps at the frame boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else if (slot_wrap_c) begin
         if (last_idx_c) idx_q <= '0;
         else            idx_q <= idx_q + IDX_W'(1);
      end
   end

   // A load coinciding with the frame boundary skips the shadow and lands in active directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_code_q <= '0;
         active_dp_q   <= '0;
         active_mask_q <= '0;
         shadow_code_q <= '0;
         shadow_dp_q   <= '0;
         shadow_mask_q <= '0;
         pending_q     <= 1'b0;
      end else if (bus.load) begin
         if (frame_edge_c) begin
            active_code_q <= bus.data_in;
            active_dp_q   <= bus.dp_in;
            active_mask_q <= bus.mask_in;
            pending_q     <= 1'b0;
         end else begin
            shadow_code_q <= bus.data_in;
            shadow_dp_q   <= bus.dp_in;
            shadow_mask_q <= bus.mask_in;
            pending_q     <= 1'b1;
         end
      end else if (frame_edge_c && pending_q) begin
         active_code_q <= shadow_code_q;
         active_dp_q   <= shadow_dp_q;
         active_mask_q <= shadow_mask_q;
         pending_q     <= 1'b0;
      end
   end

   // Leading-zero blanking: walk down from the top digit while every code seen is zero.
   always_comb begin
      lead_blank_c = '0;
      zero_run_c   = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run_c      = zero_run_c & (active_code_q[i] == '0);
         lead_blank_c[i] = bus.lzb & zero_run_c & (i != 0);
      end
   end

   assign visible_c = active_mask_q & ~lead_blank_c;

   // Registered display outputs; nothing reaches the pins without passing a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.code        <= '0;
         bus.dp          <= 1'b0;
         bus.digit_en    <= '0;
         bus.digit_idx   <= '0;
         bus.frame_start <= 1'b0;
         bus.pending     <= 1'b0;
      end else begin
         bus.code        <= active_code_q[idx_q];
         bus.dp          <= active_dp_q[idx_q];
         bus.digit_idx   <= idx_q;
         bus.digit_en    <= (bus.enable && (phase_c == PH_SHOW) && visible_c[idx_q])
                            ? onehot_c : '0;
         bus.frame_start <= bus.enable && (slot_cnt == '0) && (idx_q == '0);
         bus.pending     <= pending_q;
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Scoreboard bench for the seven-segment scan controller (4 digits, 8-cycle slots, 2 blank cycles).
module tb_seven_segment_scan_controller;

   localparam int F_CODE = 0;
   localparam int F_DP   = 1;
   localparam int F_EN   = 2;
   localparam int F_IDX  = 3;
   localparam int F_FS   = 4;
   localparam int F_PEND = 5;
   localparam int ASYNC_KEY = -1;

   typedef struct {
      int tick;
      int field;
      int val;
   } exp_t;

   exp_t sb[$];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tick  = 0;
   int   base  = 0;
   int   checks = 0;
   int   errors = 0;

   seven_segment_scan_controller_if #(.NUM_DIGITS(4)) bus ();

   seven_segment_scan_controller #(
      .NUM_DIGITS   (4),
      .PRESCALE     (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) tick <= tick + 1;

   function automatic int actual_of(input int f);
      case (f)
         F_CODE:  return int'(bus.code);
         F_DP:    return int'(bus.dp);
         F_EN:    return int'(bus.digit_en);
         F_IDX:   return int'(bus.digit_idx);
         F_FS:    return int'(bus.frame_start);
         F_PEND:  return int'(bus.pending);
         default: return -1;
      endcase
   endfunction

   function automatic string name_of(input int f);
      case (f)
         F_CODE:  return "code";
         F_DP:    return "dp";
         F_EN:    return "digit_en";
         F_IDX:   return "digit_idx";
         F_FS:    return "frame_start";
         F_PEND:  return "pending";
         default: return "unknown";
      endcase
   endfunction

   task automatic check_key(input int key);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].tick == key) begin
            int act;
            act = actual_of(sb[i].field);
            checks++;
            if (act != sb[i].val) begin
               errors++;
               $display("FAIL %s tick=%0d cycle=%0d actual=%0h expected=%0h",
                        name_of(sb[i].field), key, key - base, act, sb[i].val);
            end
            sb.delete(i);
         end
      end
   endtask

   // Monitor: compare everything due for this cycle, sampled just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         check_key(tick);
      end
   end

   initial begin
      forever begin
         @(negedge rst_n);
         #1;
         check_key(ASYNC_KEY);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog tick=%0d actual=timeout expected=finish", tick);
      $fatal(1, "watchdog expired");
   end

   task automatic expect_at(input int c, input int f, input int v);
      sb.push_back('{base + c, f, v});
   endtask

   // Next posedge after return is relative edge 'rel'.
   task automatic at_edge(input int rel);
      while (tick < base + rel - 1) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic load_at(input int rel, input logic [15:0] d, input logic [3:0] dpv,
                          input logic [3:0] m);
      at_edge(rel);
      bus.load    = 1'b1;
      bus.data_in = d;
      bus.dp_in   = dpv;
      bus.mask_in = m;
      at_edge(rel + 1);
      bus.load    = 1'b0;
   endtask

   // Frame-aligned expectations: codes/ens hold one nibble per digit, dps one bit per digit.
   task automatic expect_frame(input int start, input int len, input logic [15:0] codes,
                               input logic [3:0] dps, input logic [15:0] ens);
      for (int c = start; c < start + len; c++) begin
         int s;
         int ph;
         s  = ((c - start) / 8) % 4;
         ph = (c - start) % 8;
         expect_at(c, F_IDX, s);
         expect_at(c, F_CODE, int'(codes[4*s +: 4]));
         expect_at(c, F_DP, int'(dps[s]));
         expect_at(c, F_EN, (ph < 2) ? 0 : int'(ens[4*s +: 4]));
         expect_at(c, F_FS, (s == 0 && ph == 0) ? 1 : 0);
      end
   endtask

   initial begin
      bus.enable  = 1'b1;
      bus.load    = 1'b0;
      bus.data_in = '0;
      bus.dp_in   = '0;
      bus.mask_in = '0;
      bus.lzb     = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      base  = tick + 1;

      // Reset state, first load, commit at the frame boundary.
      expect_frame(0, 32, 16'h0000, 4'h0, 16'h0000);
      expect_frame(32, 32, 16'h4321, 4'h0, 16'h8421);
      expect_at(64, F_FS, 1);
      expect_at(64, F_IDX, 0);
      for (int c = 0; c <= 32; c++) expect_at(c, F_PEND, (c >= 4 && c <= 31) ? 1 : 0);
      load_at(3, 16'h4321, 4'h0, 4'hF);

      // Leading-zero blanking on, then off.
      expect_frame(96, 32, 16'h0050, 4'h0, 16'h0021);
      expect_frame(128, 32, 16'h0050, 4'h0, 16'h8421);
      at_edge(70);
      bus.lzb = 1'b1;
      load_at(70, 16'h0050, 4'h0, 4'hF);
      at_edge(128);
      bus.lzb = 1'b0;

      // Sparse mask with decimal points; masked digits keep their slot.
      expect_frame(160, 32, 16'h8765, 4'b0011, 16'h0401);
      load_at(130, 16'h8765, 4'b0011, 4'b0101);

      // Last load wins; load on the boundary edge goes straight to active.
      for (int c = 166; c <= 192; c++) expect_at(c, F_PEND, (c <= 191) ? 1 : 0);
      expect_frame(192, 32, 16'hBBBB, 4'h0, 16'h8421);
      load_at(165, 16'hAAAA, 4'h0, 4'hF);
      load_at(170, 16'hBBBB, 4'h0, 4'hF);
      for (int c = 201; c <= 226; c++) expect_at(c, F_PEND, (c <= 223) ? 1 : 0);
      expect_frame(224, 20, 16'h5678, 4'h0, 16'h8421);
      load_at(200, 16'hDDDD, 4'h0, 4'hF);
      load_at(223, 16'h5678, 4'h0, 4'hF);

      // Pause mid-show of digit 2 for 20 cycles, then resume the rest of the slot.
      for (int c = 244; c <= 263; c++) begin
         expect_at(c, F_IDX, 2);
         expect_at(c, F_EN, 0);
         expect_at(c, F_FS, 0);
         expect_at(c, F_CODE, 6);
      end
      for (int c = 264; c <= 267; c++) begin
         expect_at(c, F_IDX, 2);
         expect_at(c, F_EN, 4);
      end
      for (int c = 268; c <= 275; c++) begin
         expect_at(c, F_IDX, 3);
         expect_at(c, F_CODE, 5);
         expect_at(c, F_EN, (c <= 269) ? 0 : 8);
      end
      expect_at(276, F_FS, 1);
      expect_at(276, F_IDX, 0);
      expect_at(276, F_CODE, 8);
      at_edge(244);
      bus.enable = 1'b0;
      at_edge(264);
      bus.enable = 1'b1;

      // Reset mid-frame with pending data.
      for (int c = 281; c <= 287; c++) expect_at(c, F_PEND, 1);
      expect_at(287, F_EN, 2);
      expect_at(287, F_CODE, 7);
      load_at(280, 16'h9999, 4'hF, 4'hF);
      at_edge(288);
      #1;
      for (int f = F_CODE; f <= F_PEND; f++) sb.push_back('{ASYNC_KEY, f, 0});
      rst_n = 1'b0;
      at_edge(290);
      #1;
      rst_n = 1'b1;
      base  = tick + 1;
      expect_frame(0, 40, 16'h0000, 4'h0, 16'h0000);
      for (int c = 0; c <= 40; c++) expect_at(c, F_PEND, 0);
      at_edge(42);

      foreach (sb[i]) begin
         errors++;
         $display("FAIL unchecked_%s tick=%0d actual=none expected=%0h",
                  name_of(sb[i].field), sb[i].tick, sb[i].val);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
